// File: rtl/corr_disp_select_if.sv
// -----------------------------------------------------------------------------
// corr_disp_select_if
// Bundles the request/result signals of corr_disp_select.
//   nd        : new-data strobe, corr_in[] is valid in this cycle
//   corr_in[] : 21 unsigned correlation scores, disparities 0..20
//   disp_out  : disparity index of the maximum score
//   peak_out  : maximum score value
//   valid_out : one-cycle pulse, disp_out/peak_out/low_conf are new
//   low_conf  : peak_out is below the confidence threshold
//   busy      : a scan is in progress
//   ovf       : sticky, a request arrived while busy
// master drives the request side, slave is the selector itself.
// -----------------------------------------------------------------------------
interface corr_disp_select_if #(
    parameter int sh_reg_w = 8
);
    localparam int CW = 2 * sh_reg_w;

    logic          nd;
    logic [CW-1:0] corr_in [0:20];
    logic [4:0]    disp_out;
    logic [CW-1:0] peak_out;
    logic          valid_out;
    logic          low_conf;
    logic          busy;
    logic          ovf;

    modport master (
        output nd,
        output corr_in,
        input  disp_out,
        input  peak_out,
        input  valid_out,
        input  low_conf,
        input  busy,
        input  ovf
    );

    modport slave (
        input  nd,
        input  corr_in,
        output disp_out,
        output peak_out,
        output valid_out,
        output low_conf,
        output busy,
        output ovf
    );
endinterface

// File: rtl/corr_disp_select.sv
// -----------------------------------------------------------------------------
// corr_disp_select
// Picks the disparity with the largest correlation score out of 21 candidates.
// A request (nd) snapshots all scores, a sequential scan walks the snapshot one
// entry per cycle (ties keep the lowest index), and the winner is published
// 22 cycles after the request together with a low-confidence flag.
//
// Ports
//   clk : clock, all state changes on the rising edge
//   rst : synchronous, active-high reset
//   bus : corr_disp_select_if.slave (nd, corr_in[], disp_out, peak_out,
//         valid_out, low_conf, busy, ovf)
//
// Parameters
//   sh_reg_w    : score width is 2*sh_reg_w
//   conf_thresh : peaks strictly below this value are flagged low_conf
// -----------------------------------------------------------------------------
module corr_disp_select #(
    parameter int                        sh_reg_w    = 8,
    parameter logic [2*sh_reg_w-1:0]     conf_thresh = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    corr_disp_select_if.slave    bus
);
    localparam int         CW       = 2 * sh_reg_w;
    localparam logic [4:0] LAST_IDX = 5'd20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_buf [0:20];
    logic [4:0]    r_idx;
    logic [CW-1:0] r_best;
    logic [4:0]    r_best_idx;
    logic [4:0]    r_disp;
    logic [CW-1:0] r_peak;
    logic          r_valid;
    logic          r_low_conf;
    logic          r_ovf;

    logic [CW-1:0] w_entry;
    logic          w_take;
    logic [CW:0]   w_thresh_diff;
    logic          w_low;

    // Entry under inspection this cycle; entry 0 always seeds the best value,
    // later entries only replace it when strictly greater so ties stay low.
    assign w_entry = r_buf[r_idx];
    assign w_take  = (r_idx == 5'd0) || (w_entry > r_best);

    // The borrow out of best - thresh is exactly (best < thresh); written this
    // way so a zero threshold does not turn into a constant comparison.
    assign w_thresh_diff = {1'b0, r_best} - {1'b0, conf_thresh};
    assign w_low         = w_thresh_diff[CW];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_idx      <= 5'd0;
            r_disp     <= 5'd0;
            r_peak     <= '0;
            r_valid    <= 1'b0;
            r_low_conf <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.nd) begin
                        r_buf   <= bus.corr_in;
                        r_idx   <= 5'd0;
                        r_state <= SCAN;
                    end
                end

                SCAN: begin
                    // A request during a scan is dropped and remembered.
                    if (bus.nd) begin
                        r_ovf <= 1'b1;
                    end
                    if (w_take) begin
                        r_best     <= w_entry;
                        r_best_idx <= r_idx;
                    end
                    // Index stops at the last entry instead of wrapping.
                    if (r_idx == LAST_IDX) begin
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + 5'd1;
                    end
                end

                DONE: begin
                    r_disp     <= r_best_idx;
                    r_peak     <= r_best;
                    r_low_conf <= w_low;
                    r_valid    <= 1'b1;
                    // The publishing edge also serves as the accept point for
                    // the next request, giving a 22-cycle back-to-back period.
                    if (bus.nd) begin
                        r_buf   <= bus.corr_in;
                        r_idx   <= 5'd0;
                        r_state <= SCAN;
                    end else begin
                        r_state <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.disp_out  = r_disp;
    assign bus.peak_out  = r_peak;
    assign bus.valid_out = r_valid;
    assign bus.low_conf  = r_low_conf;
    assign bus.busy      = (r_state != IDLE);
    assign bus.ovf       = r_ovf;

endmodule
